// File: rtl/sna_request_receiver.sv
// sna_request_receiver
//   Request-path ingress stage of the slave network adapter. Flits from the
//   router are framing-checked and written into a flit FIFO. Only fully
//   received, well-formed packets are published downstream (committed write
//   pointer). A malformed packet is rolled back and err pulses for one cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flit_in[33:0]       {type[1:0], payload[31:0]}; type 00 head, 01 body,
//                       10 tail, 11 illegal
//   flit_in_valid/ready ingress handshake
//   addr, data          FIFO-head payload
//   read, pov_addr      FIFO-head payload[4] / payload[3:0] (head flits)
//   flit_type           FIFO-head type
//   is_valid            a committed flit is being presented
//   is_allocatable,
//   is_on_off           transmitter flow-control flags, bit VC_ID is used
//   err                 one-cycle framing-error pulse
//   err_count[7:0]      saturating framing-error count, present only when
//                       SNA_RX_ERR_CNT_EN is defined
module sna_request_receiver #(
  parameter int DEPTH = 8,
  parameter int VC_ID = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [33:0] flit_in,
  input  logic        flit_in_valid,
  output logic        flit_in_ready,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        read,
  output logic [3:0]  pov_addr,
  output logic [1:0]  flit_type,
  output logic        is_valid,
  input  logic [7:0]  is_allocatable,
  input  logic [7:0]  is_on_off,
  output logic        err
`ifdef SNA_RX_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic [1:0] {
    EXP_HEAD  = 2'd0,
    EXP_RADDR = 2'd1,
    EXP_WADDR = 2'd2,
    EXP_WDATA = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_spec_q, wr_spec_d;
  logic [PW-1:0]   wr_cmt_q, wr_cmt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic            init_q, init_d;
  logic [33:0]     mem_q [DEPTH];

  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [PW-1:0]   spec_occ;
  logic            accept;
  logic            pop;
  logic [1:0]      in_type;
  logic [33:0]     head_flit;

  assign in_type  = flit_in[33:32];
  // Speculative occupancy counts uncommitted flits too, and is taken before
  // any same-cycle pop, so a full FIFO never passes a flit through.
  assign spec_occ = wr_spec_q - rd_ptr_q;
  assign flit_in_ready = init_q && !rst && (spec_occ < PW'(DEPTH));
  assign accept   = flit_in_valid && flit_in_ready;

  assign is_valid  = (rd_ptr_q != wr_cmt_q);
  // Outputs read zero whenever nothing committed is presented, so stale or
  // uninitialised memory never leaks out.
  assign head_flit = is_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign flit_type = head_flit[33:32];
  assign addr      = head_flit[31:0];
  assign data      = head_flit[31:0];
  assign read      = head_flit[4];
  assign pov_addr  = head_flit[3:0];
  assign err       = err_q;

  // A packet may start only when the transmitter can allocate; subsequent
  // flits follow the on/off credit.
  assign pop = is_valid &&
               ((flit_type == T_HEAD) ? is_allocatable[VC_ID] : is_on_off[VC_ID]);

  always_comb begin
    state_d   = state_q;
    wr_spec_d = wr_spec_q;
    wr_cmt_d  = wr_cmt_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = 1'b0;
    init_d    = 1'b1;
    mem_we    = 1'b0;
    mem_widx  = wr_spec_q[AW-1:0];

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (accept) begin
      unique case ({state_q, in_type})
        {EXP_HEAD, T_HEAD}: begin
          mem_we    = 1'b1;
          wr_spec_d = wr_spec_q + 1'b1;
          state_d   = flit_in[4] ? EXP_RADDR : EXP_WADDR;
        end
        {EXP_WADDR, T_BODY}: begin
          mem_we    = 1'b1;
          wr_spec_d = wr_spec_q + 1'b1;
          state_d   = EXP_WDATA;
        end
        {EXP_RADDR, T_TAIL},
        {EXP_WDATA, T_TAIL}: begin
          mem_we    = 1'b1;
          wr_spec_d = wr_spec_q + 1'b1;
          wr_cmt_d  = wr_spec_q + 1'b1;
          state_d   = EXP_HEAD;
        end
        default: begin
          // Framing error: discard the partial packet. A stray head is
          // treated as the start of a fresh packet at the rolled-back slot.
          err_d = 1'b1;
          if (in_type == T_HEAD) begin
            mem_we    = 1'b1;
            mem_widx  = wr_cmt_q[AW-1:0];
            wr_spec_d = wr_cmt_q + 1'b1;
            state_d   = flit_in[4] ? EXP_RADDR : EXP_WADDR;
          end else begin
            wr_spec_d = wr_cmt_q;
            state_d   = EXP_HEAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EXP_HEAD;
      wr_spec_q <= '0;
      wr_cmt_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_spec_q <= wr_spec_d;
      wr_cmt_q  <= wr_cmt_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
      init_q    <= init_d;
    end
  end

  // Storage needs no reset: reads are masked until data is committed.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= flit_in;
  end

`ifdef SNA_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_sna_request_receiver.sv
module tb_sna_request_receiver;
  localparam int DEPTH = 8;
  localparam int VC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [33:0] flit_in = '0;
  logic        flit_in_valid = 1'b0;
  logic        flit_in_ready;
  logic [31:0] addr, data;
  logic        read;
  logic [3:0]  pov_addr;
  logic [1:0]  flit_type;
  logic        is_valid;
  logic [7:0]  is_allocatable = 8'hFF;
  logic [7:0]  is_on_off = 8'hFF;
  logic        err;
`ifdef SNA_RX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  sna_request_receiver #(.DEPTH(DEPTH), .VC_ID(VC)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .flit_in_ready(flit_in_ready), .addr(addr), .data(data), .read(read),
    .pov_addr(pov_addr), .flit_type(flit_type), .is_valid(is_valid),
    .is_allocatable(is_allocatable), .is_on_off(is_on_off), .err(err)
`ifdef SNA_RX_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: packet-level view. pend holds the packet being
  // received, cq holds committed flits awaiting delivery.
  logic [33:0] cq[$];
  logic [33:0] pend[$];
  bit          m_init = 0;
  bit          m_err = 0;
  int          m_errcnt = 0;
  int          m_errs = 0;
  int          m_deliv = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_init && !rst && ((cq.size() + pend.size()) < DEPTH);
  endfunction

  function automatic bit ty_legal(logic [1:0] ty);
    case (ty)
      2'b00:   return pend.size() == 0;
      2'b01:   return pend.size() == 1 && !pend[0][4];
      2'b10:   return (pend.size() == 1 && pend[0][4]) || pend.size() == 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] next_legal_ty();
    if (pend.size() == 0) return 2'b00;
    if (pend[0][4])       return 2'b10;
    if (pend.size() == 1) return 2'b01;
    return 2'b10;
  endfunction

  task automatic model_accept(logic [33:0] f);
    if (ty_legal(f[33:32])) begin
      pend.push_back(f);
      if (f[33:32] == 2'b10) begin
        foreach (pend[i]) cq.push_back(pend[i]);
        pend.delete();
      end
    end else begin
      m_err = 1;
      m_errs++;
      if (m_errcnt < 255) m_errcnt++;
      pend.delete();
      if (f[33:32] == 2'b00) pend.push_back(f);
    end
  endtask

  task automatic check_model();
    logic [33:0] h;
    h = (cq.size() > 0) ? cq[0] : 34'h0;
    chk("ready", flit_in_ready, m_ready());
    chk("is_valid", is_valid, cq.size() > 0);
    chk("err", err, m_err);
    chk("flit_type", flit_type, h[33:32]);
    chk("addr", addr, h[31:0]);
    chk("data", data, h[31:0]);
    chk("read", read, h[4]);
    chk("pov_addr", pov_addr, h[3:0]);
`ifdef SNA_RX_ERR_CNT_EN
    chk("err_count", err_count, m_errcnt);
`endif
  endtask

  // One clock: check outputs mid-cycle, then advance the model over the edge.
  task automatic step();
    bit acc, pop;
    logic [33:0] f;
    @(negedge clk);
    check_model();
    acc = flit_in_valid && m_ready();
    pop = (cq.size() > 0) &&
          ((cq[0][33:32] == 2'b00) ? is_allocatable[VC] : is_on_off[VC]);
    f = flit_in;
    @(posedge clk);
    if (rst) begin
      cq.delete(); pend.delete();
      m_init = 0; m_err = 0; m_errcnt = 0;
    end else begin
      m_init = 1; m_err = 0;
      if (pop) begin void'(cq.pop_front()); m_deliv++; end
      if (acc) model_accept(f);
    end
    #1;
  endtask

  task automatic send(logic [1:0] ty, logic [31:0] pl);
    bit done = 0;
    flit_in_valid = 1'b1;
    flit_in = {ty, pl};
    for (int i = 0; i < 100 && !done; i++) begin
      done = m_ready();
      step();
    end
    if (!done) chk("send_timeout", 0, 1);
    flit_in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (cq.size() > 0 && i < 100) begin step(); i++; end
    chk("drain_timeout", cq.size(), 0);
    step();
  endtask

  typedef struct {
    bit          v;
    logic [1:0]  ty;
    logic [31:0] pl;
    bit          e_rdy;
    bit          e_iv;
    logic [1:0]  e_ty;
    logic [31:0] e_pl;
    bit          e_err;
  } vec_t;

  function automatic vec_t mk(bit v, logic [1:0] ty, logic [31:0] pl, bit e_rdy,
                              bit e_iv, logic [1:0] e_ty, logic [31:0] e_pl, bit e_err);
    vec_t r;
    r.v = v; r.ty = ty; r.pl = pl; r.e_rdy = e_rdy;
    r.e_iv = e_iv; r.e_ty = e_ty; r.e_pl = e_pl; r.e_err = e_err;
    return r;
  endfunction

  vec_t tbl[15];

  initial begin
    int k, d0, e0;
    logic [33:0] pk[9];

    // Directed vectors from the cycle rst is first low. Read packet, a
    // head(write)+tail framing error, then a clean read packet.
    tbl[0]  = mk(0, 2'b00, 32'h0,         0, 0, 2'b00, 32'h0,         0);
    tbl[1]  = mk(1, 2'b00, 32'h15,        1, 0, 2'b00, 32'h0,         0);
    tbl[2]  = mk(1, 2'b10, 32'h4000_0000, 1, 0, 2'b00, 32'h0,         0);
    tbl[3]  = mk(0, 2'b00, 32'h0,         1, 1, 2'b00, 32'h15,        0);
    tbl[4]  = mk(0, 2'b00, 32'h0,         1, 1, 2'b10, 32'h4000_0000, 0);
    tbl[5]  = mk(0, 2'b00, 32'h0,         1, 0, 2'b00, 32'h0,         0);
    tbl[6]  = mk(1, 2'b00, 32'h03,        1, 0, 2'b00, 32'h0,         0);
    tbl[7]  = mk(1, 2'b10, 32'h99,        1, 0, 2'b00, 32'h0,         0);
    tbl[8]  = mk(0, 2'b00, 32'h0,         1, 0, 2'b00, 32'h0,         1);
    tbl[9]  = mk(0, 2'b00, 32'h0,         1, 0, 2'b00, 32'h0,         0);
    tbl[10] = mk(1, 2'b00, 32'h11,        1, 0, 2'b00, 32'h0,         0);
    tbl[11] = mk(1, 2'b10, 32'h55,        1, 0, 2'b00, 32'h0,         0);
    tbl[12] = mk(0, 2'b00, 32'h0,         1, 1, 2'b00, 32'h11,        0);
    tbl[13] = mk(0, 2'b00, 32'h0,         1, 1, 2'b10, 32'h55,        0);
    tbl[14] = mk(0, 2'b00, 32'h0,         1, 0, 2'b00, 32'h0,         0);

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    foreach (tbl[i]) begin
      flit_in_valid = tbl[i].v;
      flit_in = {tbl[i].ty, tbl[i].pl};
      chk($sformatf("tbl%0d_rdy", i), flit_in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_iv", i), is_valid, tbl[i].e_iv);
      chk($sformatf("tbl%0d_ty", i), flit_type, tbl[i].e_ty);
      chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_pl);
      chk($sformatf("tbl%0d_data", i), data, tbl[i].e_pl);
      chk($sformatf("tbl%0d_read", i), read, tbl[i].e_pl[4]);
      chk($sformatf("tbl%0d_pov", i), pov_addr, tbl[i].e_pl[3:0]);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      step();
    end
    flit_in_valid = 1'b0;

    // Write packet with on/off credit withheld: head pops, body waits.
    is_on_off = 8'hFF & ~(8'h1 << VC);
    send(2'b00, 32'h03);
    send(2'b01, 32'h8000_0010);
    send(2'b10, 32'hDEAD_BEEF);
    repeat (4) step();
    chk("wr_hold_iv", is_valid, 1);
    chk("wr_hold_ty", flit_type, 2'b01);
    chk("wr_hold_addr", addr, 32'h8000_0010);
    is_on_off = 8'hFF;
    drain();

    // Head in the middle of a write packet restarts as a read packet.
    d0 = m_deliv; e0 = m_errs;
    send(2'b00, 32'h03);
    send(2'b01, 32'h8000_0010);
    send(2'b00, 32'h17);
    send(2'b10, 32'h1234);
    drain();
    chk("mid_head_errs", m_errs - e0, 1);
    chk("mid_head_deliv", m_deliv - d0, 2);

    // Full / wrap: downstream blocked, three write packets streamed.
    is_allocatable = 8'hFF & ~(8'h1 << VC);
    is_on_off      = 8'hFF & ~(8'h1 << VC);
    for (int p = 0; p < 3; p++) begin
      pk[3*p]   = {2'b00, 32'h0000_0100 + 32'(p)};
      pk[3*p+1] = {2'b01, 32'hA000_0000 + 32'(p)};
      pk[3*p+2] = {2'b10, 32'hD000_0000 + 32'(p)};
    end
    d0 = m_deliv;
    k = 0;
    flit_in_valid = 1'b1;
    for (int i = 0; i < 20 && k < 9; i++) begin
      bit a;
      flit_in = pk[k];
      a = m_ready();
      step();
      if (a) k++;
    end
    chk("full_accepted", k, 8);
    chk("full_rdy", flit_in_ready, 0);
    chk("full_iv", is_valid, 1);
    is_allocatable = 8'hFF;
    is_on_off = 8'hFF;
    for (int i = 0; i < 40 && k < 9; i++) begin
      bit a;
      flit_in = pk[k];
      a = m_ready();
      step();
      if (a) k++;
    end
    flit_in_valid = 1'b0;
    drain();
    chk("wrap_deliv", m_deliv - d0, 9);

    // Reset in the middle of a packet: the tail afterwards is an error.
    send(2'b00, 32'h03);
    send(2'b01, 32'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(2'b10, 32'h5);
    chk("rst_tail_err", err, 1);
    chk("rst_tail_iv", is_valid, 0);
    repeat (3) step();

    // Randomised traffic, mostly well-formed, with corruption and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ty;
      ty = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : next_legal_ty();
      flit_in_valid  = ($urandom_range(0, 3) != 0);
      flit_in        = {ty, $urandom()};
      is_allocatable = 8'($urandom()) | (($urandom_range(0, 1) != 0) ? (8'h1 << VC) : 8'h0);
      is_on_off      = 8'($urandom()) | (($urandom_range(0, 2) != 0) ? (8'h1 << VC) : 8'h0);
      rst            = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    flit_in_valid = 1'b0;
    is_allocatable = 8'hFF;
    is_on_off = 8'hFF;
    step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sna_request_receiver.md
# sna_request_receiver

Slave-network-adapter request-path ingress stage: accepts request flits from the NoC router port, checks packet framing, and buffers complete packets in a flit FIFO. It presents buffered flits one at a time to the SNA request transmitter, using the transmitter's per-VC allocatable/on-off flags as flow control. Only framing-correct, fully received packets become visible downstream; malformed packets are rolled back and flagged.

## Interface
Parameters:
- DEPTH, 8: flit FIFO entries; power of 2, minimum 4.
- VC_ID, 0: bit index (0..7) of is_allocatable/is_on_off used for flow control.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flit_in  in  34  [33:32] type (00 head, 01 body, 10 tail, 11 illegal), [31:0] payload.
- flit_in_valid  in  1  router presents flit.
- flit_in_ready  out  1  flit accepted when valid && ready.
- addr  out  32  FIFO-head payload [31:0].
- data  out  32  FIFO-head payload [31:0].
- read  out  1  FIFO-head payload [4]; meaningful on head flits.
- pov_addr  out  4  FIFO-head payload [3:0]: return (source) node address; meaningful on head flits.
- flit_type  out  2  FIFO-head type.
- is_valid  out  1  committed flit presented.
- is_allocatable  in  8  transmitter can start a packet (bit VC_ID).
- is_on_off  in  8  transmitter can take the next flit (bit VC_ID).
- err  out  1  one-cycle pulse on framing error.

## Operation
- Packet formats:
  - Read: head (payload[4]=1), then tail carrying the address.
  - Write: head (payload[4]=0), then body carrying the address, then tail carrying the data.
- Ingress checker FSM: EXP_HEAD, EXP_RADDR, EXP_WADDR, EXP_WDATA.
  - EXP_HEAD + head: go to EXP_RADDR if payload[4]=1, else EXP_WADDR.
  - EXP_RADDR + tail: commit, go to EXP_HEAD.
  - EXP_WADDR + body: go to EXP_WDATA.
  - EXP_WDATA + tail: commit, go to EXP_HEAD.
- Storage: every accepted flit is written at the speculative write pointer (wr_spec). Commit copies wr_spec (including the current flit) into the committed pointer wr_cmt.
- Framing error (any other type/state pair, including type 11):
  - Pulse err.
  - Roll back: wr_spec <= wr_cmt.
  - An erroneous head restarts a new packet: it is stored at the rolled-back position and the FSM goes to EXP_RADDR/EXP_WADDR.
  - Any other erroneous flit is dropped, FSM goes to EXP_HEAD.
- flit_in_ready = (speculative occupancy < DEPTH). Free slots are counted before the same-cycle pop (no pass-through at full).
- Egress: is_valid = (rd_ptr != wr_cmt, committed occupancy > 0). Output fields are driven combinationally from mem[rd_ptr].
- Pop condition: is_valid && (flit_type==00 ? is_allocatable[VC_ID] : is_on_off[VC_ID]). On pop, rd_ptr increments.
- Pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. Wrap-around is natural modulo 2·DEPTH.
- Push, commit and pop in the same cycle are all legal; occupancies update consistently.

## Timing
- Reset (any cycle, including mid-packet): pointers 0, FSM EXP_HEAD, is_valid 0, err 0, flit_in_ready 0. flit_in_ready rises to 1 the cycle after rst deasserts. A partial packet is discarded.
- Committed-data outputs are all-zero while empty after reset (memory is not required to be cleared).
- Latency: a tail accepted at edge N makes its packet's head flit visible (is_valid=1) from edge N, i.e. in the cycle after acceptance.
- err is high for exactly the cycle after the offending flit is accepted.
- Throughput: one flit in and one flit out per cycle.

## Configuration
- SNA_RX_ERR_CNT_EN defined:
  - Adds output err_count [7:0]: saturating count of framing errors.
  - Reset to 0; sticks at 255.
- Undefined: the port and counter are absent; err pulse only.

## Test plan
- Read packet: head 0x0000_0015, tail 0x4000_0000 with is_allocatable/is_on_off all 1 -> head flit shows read=1, pov_addr=5; next cycle addr=0x4000_0000; then is_valid=0.
- Write packet: head 0x03, body 0x8000_0010, tail 0xDEAD_BEEF with is_on_off[VC_ID]=0 held -> head pops; body stays presented until is_on_off[VC_ID]=1; data=0xDEAD_BEEF last.
- Framing error: head(write), tail -> err pulses once; is_valid stays 0; occupancy returns to the pre-packet value; the next legal read packet is delivered intact.
- Head mid-packet: head(write), body, head(read 0x17), tail 0x1234 -> one err pulse; only the read packet is delivered, with pov_addr=7.
- Full/wrap: DEPTH=8, downstream blocked, stream 3 write packets -> flit_in_ready drops after 8 flits with the third packet uncommitted. Unblock -> all 9 flits delivered in order across pointer wrap.
- Reset mid-packet: head, body, then rst for 1 cycle, then tail -> is_valid never asserts; tail flagged as err (FSM in EXP_HEAD).
